// File: rtl/kbd_pkg.sv
// Shared scancode constants and FSM state type for the PS/2 keyboard scan controller.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_LANG   = 8'h0E;

  localparam logic [7:0] NO_CHAR_DEFAULT = 8'd254;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK,
    ST_LOOKUP
  } kbd_state_e;

endpackage

// File: rtl/kbd_scan_controller.sv
// Decodes set-2 scancode bytes (break/extended prefixes, modifiers) and strobes
// one mapped character per printable make code; the mapper sits outside this block.
module kbd_scan_controller
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  NO_CHAR        = NO_CHAR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] map_key,
  output logic       map_shift,
  output logic       map_capLock,
  output logic       map_changeToThai,
  input  logic [7:0] map_char,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       caps_led,
  output logic       thai_led,
  output logic       overflow
);

  kbd_state_e  state_q;
  logic [7:0]  map_key_q;
  logic [7:0]  char_out_q;
  logic        char_valid_q;
  logic        lshift_q, rshift_q, caps_held_q, lang_held_q;
  logic        caps_q, thai_q;
  logic        overflow_q;
  logic [7:0]  skid_q;
  logic        skid_full_q;
  logic [31:0] tmo_q;

  logic        have_byte;
  logic [7:0]  rx_byte;

  // Outside LOOKUP a pending skid byte takes priority over the live input.
  always_comb begin
    have_byte = 1'b0;
    rx_byte   = scan_code;
    if (state_q != ST_LOOKUP) begin
      have_byte = skid_full_q | scan_valid;
      rx_byte   = skid_full_q ? skid_q : scan_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      map_key_q    <= '0;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      caps_held_q  <= 1'b0;
      lang_held_q  <= 1'b0;
      caps_q       <= 1'b0;
      thai_q       <= 1'b0;
      overflow_q   <= 1'b0;
      skid_q       <= '0;
      skid_full_q  <= 1'b0;
      tmo_q        <= '0;
    end else begin
      char_valid_q <= 1'b0;
      if (state_q == ST_LOOKUP) begin
        if (scan_valid) begin
          if (skid_full_q) begin
            overflow_q <= 1'b1;
          end else begin
            skid_q      <= scan_code;
            skid_full_q <= 1'b1;
          end
        end
        if (map_char != NO_CHAR) begin
          char_out_q   <= map_char;
          char_valid_q <= 1'b1;
        end
        map_key_q <= '0;
        state_q   <= ST_IDLE;
      end else begin
        // A byte arriving while the skid drains has nowhere to go.
        if (skid_full_q) begin
          skid_full_q <= 1'b0;
          if (scan_valid) overflow_q <= 1'b1;
        end
        if (have_byte) begin
          tmo_q <= '0;
          case (state_q)
            ST_IDLE: begin
              if (rx_byte == SC_BREAK) begin
                state_q <= ST_BRK;
              end else if (rx_byte == SC_EXT) begin
                state_q <= ST_EXT;
              end else if (rx_byte == SC_LSHIFT) begin
                lshift_q <= 1'b1;
              end else if (rx_byte == SC_RSHIFT) begin
                rshift_q <= 1'b1;
              end else if (rx_byte == SC_CAPS) begin
                if (!caps_held_q) caps_q <= ~caps_q;
                caps_held_q <= 1'b1;
              end else if (rx_byte == SC_LANG) begin
                if (!lang_held_q) thai_q <= ~thai_q;
                lang_held_q <= 1'b1;
              end else begin
                map_key_q <= rx_byte;
                state_q   <= ST_LOOKUP;
              end
            end
            ST_BRK: begin
              if (rx_byte == SC_LSHIFT) lshift_q    <= 1'b0;
              if (rx_byte == SC_RSHIFT) rshift_q    <= 1'b0;
              if (rx_byte == SC_CAPS)   caps_held_q <= 1'b0;
              if (rx_byte == SC_LANG)   lang_held_q <= 1'b0;
              state_q <= ST_IDLE;
            end
            ST_EXT:  state_q <= (rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            default: state_q <= ST_IDLE;
          endcase
        end else if (state_q != ST_IDLE) begin
          if (tmo_q == TIMEOUT_CYCLES - 1) begin
            tmo_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
      end
    end
  end

  assign map_key          = map_key_q;
  assign map_shift        = lshift_q | rshift_q;
  assign map_capLock      = caps_q;
  assign map_changeToThai = thai_q;
  assign char_out         = char_out_q;
  assign char_valid       = char_valid_q;
  assign caps_led         = caps_q;
  assign thai_led         = thai_q;
  assign overflow         = overflow_q;

endmodule
